seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Serial pattern transmitter: the stimulus end of the overlapping sequence-detector chain.
//  Accepts a PAT_W-bit pattern plus a repeat count and emits it MSB-first, one bit/clk, on `out`.
//  Optional idle gap cycles between repetitions. Drives the `in` pin of seq_det_110_mealy
//  and sibling detectors, giving deterministic streams in place of $random.
// PARAMETERS
//  PAT_W    3       pattern length in bits (>=2)
//  CNT_W    4       width of repeat counter; max repetitions 2**CNT_W-1
//  GAP      0       idle cycles (out=0, out_valid=0) inserted between repetitions
// PORTS
//  clk        in   1      rising-edge clock, sole clock domain
//  rstn       in   1      synchronous active-low reset
//  start      in   1      request; accepted only when ready=1
//  pattern    in   PAT_W  bits to send, MSB transmitted first; sampled on accept
//  repeat_n   in   CNT_W  number of back-to-back repetitions; sampled on accept
//  out        out  1      serial data bit (0 when not sending)
//  out_valid  out  1      1 while `out` carries a pattern bit
//  ready      out  1      1 in IDLE only
//  busy       out  1      1 from accept until done pulse, inclusive
//  done       out  1      one-cycle pulse after final bit
// BEHAVIOUR
//  Reset (rstn=0 at posedge): state=IDLE; out=0, out_valid=0, busy=0, done=0, ready=1;
//   shift reg, bit counter, rep counter cleared. Mid-operation reset aborts with no done pulse.
//  All outputs registered. States: IDLE, SEND, GAP, FIN.
//  IDLE: ready=1. start=1 -> latch pattern into shift reg, rep_cnt=repeat_n, bit_cnt=0, busy=1.
//   repeat_n!=0 -> SEND; repeat_n==0 -> FIN (no bits sent).
//  Latency: first bit (pattern[PAT_W-1]) on out with out_valid=1 in the cycle after accept.
//  SEND: each cycle shift left, present next MSB, bit_cnt++. On bit_cnt==PAT_W-1 (last bit):
//   rep_cnt-1==0 -> FIN; else rep_cnt--, reload shift reg from latched copy (not the live
//   pattern port), and go to GAP if GAP>0, else stay in SEND with next rep's MSB
//   on the following cycle (no bubble).
//  GAP: out=0, out_valid=0 for exactly GAP cycles, then SEND.
//  FIN: done=1 for one cycle, busy=1, out_valid=0; next state IDLE (ready=1 next cycle).
//  start while busy is ignored; pattern/repeat_n changes after accept have no effect.
//  start asserted in the FIN cycle is ignored; it is accepted next cycle if still high.
//  Total cycles accept->done = repeat_n*PAT_W + (repeat_n-1)*GAP + 1.
//  Counter widths: bit_cnt = $clog2(PAT_W); rep_cnt = CNT_W, never wraps (checked for 0 first).
// STRUCTURE
//  Shared package seq_pkg: state encoding localparams (IDLE/SEND/GAP/FIN), constant
//   PAT_110 = 3'b110 and sibling detector patterns, reused by detectors and benches.
//  Single module; no sub-module -- shift reg, two counters and a 4-state FSM stay flat.
//  Shift reg and latched-pattern copy are separate PAT_W-bit registers.
// TESTING
//  Directed bench instantiating seq_pattern_gen driving seq_det_110_mealy, sharing clk/rstn:
//  1) rstn low 4 clks -> out=0, out_valid=0, busy=0, done=0, ready=1 throughout.
//  2) pattern=3'b110, repeat_n=1, GAP=0 -> out 1,1,0 on cycles 1-3 after accept; done at cycle 4;
//     detector out pulses once.
//  3) pattern=3'b110, repeat_n=3, GAP=0 -> stream 110110110 with out_valid solid 9 cycles,
//     done at cycle 10; detector fires 3 times.
//  4) repeat_n=0 -> no out_valid, done the cycle after accept, busy high exactly 1 cycle.
//  5) GAP=2, pattern=3'b101, repeat_n=2 -> 1,0,1,gap,gap,1,0,1; done 9 cycles after accept;
//     start pulse and pattern change mid-send ignored.
//  6) rstn low during 2nd repetition -> next cycle all outputs at reset values, no done pulse;
//     new start after rstn=1 sends correctly.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants for the sequence-detector chain: FSM encoding for the
// pattern generator and the reference patterns used by detectors and benches.
package seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [2:0] PAT_110  = 3'b110;
    localparam logic [2:0] PAT_101  = 3'b101;
    localparam logic [2:0] PAT_011  = 3'b011;
    localparam logic [3:0] PAT_1011 = 4'b1011;
    localparam logic [3:0] PAT_1001 = 4'b1001;

endpackage

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeat_n times, with optional idle gaps, to feed the sequence detectors.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             out,
    output logic             out_valid,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [1:0]       state;
    logic [PAT_W-1:0] sreg;
    logic [PAT_W-1:0] pat_q;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // sreg holds the bits still to be sent; out already carries the current one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            pat_q     <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        rep_cnt <= repeat_n;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        if (repeat_n != '0) begin
                            state     <= ST_SEND;
                            out       <= pattern[PAT_W-1];
                            out_valid <= 1'b1;
                            sreg      <= pattern << 1;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rep_cnt == CNT_W'(1)) begin
                            state     <= ST_FIN;
                            rep_cnt   <= '0;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else if (GAP > 0) begin
                            state     <= ST_GAP;
                            rep_cnt   <= rep_cnt - CNT_W'(1);
                            gap_cnt   <= '0;
                            sreg      <= pat_q;
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                        end else begin
                            // Back-to-back repetition: next MSB with no bubble.
                            rep_cnt <= rep_cnt - CNT_W'(1);
                            out     <= pat_q[PAT_W-1];
                            sreg    <= pat_q << 1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        out     <= sreg[PAT_W-1];
                        sreg    <= sreg << 1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= ST_SEND;
                        out       <= sreg[PAT_W-1];
                        out_valid <= 1'b1;
                        sreg      <= sreg << 1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    ready     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP=0 and GAP=2) checked cycle by
// cycle against a stream model built from pattern, repeat count and gap.
module tb_seq_pattern_gen;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [1:0]      start = '0;
    logic [1:0][2:0] pattern = '0;
    logic [1:0][3:0] rep = '0;
    logic [1:0] out, ov, rdy, bsy, dn;

    int errors = 0;
    int checks = 0;

    bit eo[$], ev[$], ed[$], eb[$], er[$];

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(3), .CNT_W(4), .GAP(0)) u_g0 (
        .clk(clk), .rstn(rstn), .start(start[0]), .pattern(pattern[0]),
        .repeat_n(rep[0]), .out(out[0]), .out_valid(ov[0]), .ready(rdy[0]),
        .busy(bsy[0]), .done(dn[0]));

    seq_pattern_gen #(.PAT_W(3), .CNT_W(4), .GAP(2)) u_g2 (
        .clk(clk), .rstn(rstn), .start(start[1]), .pattern(pattern[1]),
        .repeat_n(rep[1]), .out(out[1]), .out_valid(ov[1]), .ready(rdy[1]),
        .busy(bsy[1]), .done(dn[1]));

    function automatic void clear_exp();
        eo.delete(); ev.delete(); ed.delete(); eb.delete(); er.delete();
    endfunction

    function automatic void push_exp(bit o, bit v, bit d, bit b, bit r);
        eo.push_back(o); ev.push_back(v); ed.push_back(d);
        eb.push_back(b); er.push_back(r);
    endfunction

    // Expected per-cycle stream following an accept: bits, gaps, then done.
    function automatic void build_exp(int gap, logic [2:0] p, int n);
        for (int r = 0; r < n; r++) begin
            for (int b = 2; b >= 0; b--) push_exp(p[b], 1'b1, 1'b0, 1'b1, 1'b0);
            if (r < n - 1)
                for (int g = 0; g < gap; g++) push_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        push_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction

    task automatic run_xfer(input int sel, input logic [2:0] p, input logic [3:0] n,
                            input bit noise, input string name, output int hits);
        int waitc;
        logic [2:0] hist;
        hits = 0;
        hist = '0;
        waitc = 0;
        @(negedge clk);
        while (rdy[sel] !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (rdy[sel] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait ready=%b want 1", name, rdy[sel]);
        end
        start[sel] = 1'b1;
        pattern[sel] = p;
        rep[sel] = n;
        @(posedge clk);
        #1 start[sel] = 1'b0;
        clear_exp();
        build_exp(sel == 1 ? 2 : 0, p, int'(n));
        foreach (eo[k]) begin
            @(negedge clk);
            hist = {hist[1:0], out[sel]};
            if (hist == 3'b110) hits++;
            checks++;
            if ({out[sel], ov[sel], dn[sel], bsy[sel], rdy[sel]} !== {eo[k], ev[k], ed[k], eb[k], er[k]}) begin
                errors++;
                $display("FAIL %s cyc%0d out/valid/done/busy/ready=%b want %b", name, k + 1,
                         {out[sel], ov[sel], dn[sel], bsy[sel], rdy[sel]},
                         {eo[k], ev[k], ed[k], eb[k], er[k]});
            end
            if (noise) begin
                start[sel] = 1'($urandom);
                pattern[sel] = 3'($urandom);
                rep[sel] = 4'($urandom);
            end
        end
        @(negedge clk);
        start[sel] = 1'b0;
        checks++;
        if ({out[sel], ov[sel], dn[sel], bsy[sel], rdy[sel]} !== 5'b00001) begin
            errors++;
            $display("FAIL %s post_done out/valid/done/busy/ready=%b want 00001", name,
                     {out[sel], ov[sel], dn[sel], bsy[sel], rdy[sel]});
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if ({out[s], ov[s], dn[s], bsy[s], rdy[s]} !== 5'b00001) begin
                    errors++;
                    $display("FAIL reset inst%0d out/valid/done/busy/ready=%b want 00001", s,
                             {out[s], ov[s], dn[s], bsy[s], rdy[s]});
                end
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_single();
        int hits;
        run_xfer(0, PAT_110, 4'd1, 1'b0, "single", hits);
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL single_detect hits=%0d want 1", hits);
        end
    endtask

    task automatic test_repeat();
        int hits;
        run_xfer(0, PAT_110, 4'd3, 1'b0, "repeat3", hits);
        checks++;
        if (hits !== 3) begin
            errors++;
            $display("FAIL repeat3_detect hits=%0d want 3", hits);
        end
        run_xfer(0, PAT_110, 4'd15, 1'b1, "repeat15", hits);
        checks++;
        if (hits !== 15) begin
            errors++;
            $display("FAIL repeat15_detect hits=%0d want 15", hits);
        end
    endtask

    task automatic test_zero();
        int hits;
        run_xfer(0, PAT_110, 4'd0, 1'b0, "zero_rep", hits);
        run_xfer(1, PAT_101, 4'd0, 1'b0, "zero_rep_gap", hits);
    endtask

    task automatic test_gap();
        int hits;
        run_xfer(1, PAT_101, 4'd2, 1'b1, "gap2", hits);
        run_xfer(1, PAT_110, 4'd3, 1'b1, "gap3", hits);
        checks++;
        if (hits !== 3) begin
            errors++;
            $display("FAIL gap3_detect hits=%0d want 3", hits);
        end
    endtask

    // start held high: ignored during SEND and FIN, taken again once ready.
    task automatic test_back_to_back();
        @(negedge clk);
        start[0] = 1'b1;
        pattern[0] = PAT_110;
        rep[0] = 4'd1;
        @(posedge clk);
        #1 pattern[0] = PAT_011;
        rep[0] = 4'd2;
        clear_exp();
        build_exp(0, PAT_110, 1);
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        build_exp(0, PAT_011, 2);
        push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (eo[k]) begin
            @(negedge clk);
            checks++;
            if ({out[0], ov[0], dn[0], bsy[0], rdy[0]} !== {eo[k], ev[k], ed[k], eb[k], er[k]}) begin
                errors++;
                $display("FAIL b2b cyc%0d out/valid/done/busy/ready=%b want %b", k + 1,
                         {out[0], ov[0], dn[0], bsy[0], rdy[0]},
                         {eo[k], ev[k], ed[k], eb[k], er[k]});
            end
            if (k == 5) start[0] = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        int hits;
        @(negedge clk);
        start[0] = 1'b1;
        pattern[0] = PAT_110;
        rep[0] = 4'd3;
        @(posedge clk);
        #1 start[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if ({ov[0], dn[0], bsy[0]} !== 3'b101) begin
                errors++;
                $display("FAIL midrst_pre cyc%0d valid/done/busy=%b want 101", k,
                         {ov[0], dn[0], bsy[0]});
            end
        end
        rstn = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if ({out[0], ov[0], dn[0], bsy[0], rdy[0]} !== 5'b00001) begin
                errors++;
                $display("FAIL midrst_abort cyc%0d out/valid/done/busy/ready=%b want 00001", k,
                         {out[0], ov[0], dn[0], bsy[0], rdy[0]});
            end
            rstn = 1'b1;
        end
        run_xfer(0, PAT_110, 4'd1, 1'b0, "after_reset", hits);
        checks++;
        if (hits !== 1) begin
            errors++;
            $display("FAIL after_reset_detect hits=%0d want 1", hits);
        end
    endtask

    task automatic test_random();
        int hits;
        for (int i = 0; i < 12; i++)
            run_xfer(int'($urandom_range(0, 1)), 3'($urandom), 4'($urandom_range(0, 5)),
                     1'b1, $sformatf("rand%0d", i), hits);
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_zero();
        test_gap();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
